// File: rtl/instruction_decode_if.sv
// IF/ID, write-back and ID/EX signal bundle for the RV32I decode stage.
interface instruction_decode_if #(parameter int XLEN = 32);
  logic [31:0]     if_id_instruction;
  logic [XLEN-1:0] if_id_npc;
  logic            flush;
  logic            wb_reg_write;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            stall;
  logic [XLEN-1:0] id_ex_npc;
  logic [XLEN-1:0] id_ex_rs1_data;
  logic [XLEN-1:0] id_ex_rs2_data;
  logic [XLEN-1:0] id_ex_imm;
  logic [4:0]      id_ex_rs1;
  logic [4:0]      id_ex_rs2;
  logic [4:0]      id_ex_rd;
  logic [3:0]      id_ex_funct;
  logic            id_ex_reg_write;
  logic            id_ex_mem_read;
  logic            id_ex_mem_write;
  logic            id_ex_mem_to_reg;
  logic            id_ex_branch;
  logic            id_ex_alu_src;
  logic [1:0]      id_ex_alu_op;

  modport master (
    output if_id_instruction, if_id_npc, flush, wb_reg_write, wb_rd, wb_data,
    input  stall, id_ex_npc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct, id_ex_reg_write,
           id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch,
           id_ex_alu_src, id_ex_alu_op
  );

  modport slave (
    input  if_id_instruction, if_id_npc, flush, wb_reg_write, wb_rd, wb_data,
    output stall, id_ex_npc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm,
           id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct, id_ex_reg_write,
           id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_branch,
           id_ex_alu_src, id_ex_alu_op
  );
endinterface

// File: rtl/instruction_decode.sv
// RV32I ID stage: register file, immediate/control decode, load-use stall, ID/EX register.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-back data is forwarded to register reads.
module instruction_decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input logic                clock,
  input logic                reset,
  instruction_decode_if.slave bus
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] npc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      funct;
    ctrl_t           ctrl;
  } id_ex_t;

  logic [XLEN-1:0] regs_q [NREG];
  id_ex_t          id_ex_q;
  id_ex_t          id_ex_d;

  logic [31:0]     instr_s;
  logic [6:0]      opcode_s;
  logic [4:0]      rs1_idx_s;
  logic [4:0]      rs2_idx_s;
  ctrl_t           ctrl_s;
  logic [XLEN-1:0] imm_s;
  logic            rs2_used_s;
  logic [XLEN-1:0] rs1_val_s;
  logic [XLEN-1:0] rs2_val_s;
  logic            stall_s;

  assign instr_s   = bus.if_id_instruction;
  assign opcode_s  = instr_s[6:0];
  assign rs1_idx_s = instr_s[19:15];
  assign rs2_idx_s = instr_s[24:20];

  // Opcode decode: control bundle, immediate format and whether rs2 is a real source.
  always_comb begin
    ctrl_s     = '0;
    imm_s      = '0;
    rs2_used_s = 1'b0;
    case (opcode_s)
      OP_R: begin
        ctrl_s     = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        rs2_used_s = 1'b1;
      end
      OP_IALU: begin
        ctrl_s = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10};
        imm_s  = {{(XLEN-12){instr_s[31]}}, instr_s[31:20]};
      end
      OP_LOAD: begin
        ctrl_s = {1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00};
        imm_s  = {{(XLEN-12){instr_s[31]}}, instr_s[31:20]};
      end
      OP_STORE: begin
        ctrl_s     = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
        imm_s      = {{(XLEN-12){instr_s[31]}}, instr_s[31:25], instr_s[11:7]};
        rs2_used_s = 1'b1;
      end
      OP_BRANCH: begin
        ctrl_s     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
        imm_s      = {{(XLEN-13){instr_s[31]}}, instr_s[31], instr_s[7],
                      instr_s[30:25], instr_s[11:8], 1'b0};
        rs2_used_s = 1'b1;
      end
      default: begin
        ctrl_s     = '0;
        imm_s      = '0;
        rs2_used_s = 1'b0;
      end
    endcase
  end

  // Register file read ports; x0 is forced to zero rather than relying on stored contents.
  always_comb begin
    if (rs1_idx_s == 5'd0) begin
      rs1_val_s = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (bus.wb_reg_write && (bus.wb_rd == rs1_idx_s)) begin
      rs1_val_s = bus.wb_data;
    end
`endif
    else begin
      rs1_val_s = regs_q[rs1_idx_s];
    end
    if (rs2_idx_s == 5'd0) begin
      rs2_val_s = '0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (bus.wb_reg_write && (bus.wb_rd == rs2_idx_s)) begin
      rs2_val_s = bus.wb_data;
    end
`endif
    else begin
      rs2_val_s = regs_q[rs2_idx_s];
    end
  end

  // Load-use hazard against the load now in EX; a flush squashes the consumer so no hold is needed.
  always_comb begin
    stall_s = id_ex_q.ctrl.mem_read && (id_ex_q.rd != 5'd0) &&
              ((id_ex_q.rd == rs1_idx_s) || (rs2_used_s && (id_ex_q.rd == rs2_idx_s))) &&
              !bus.flush;
  end

  // Next ID/EX contents: bubble on flush or stall, decoded instruction otherwise.
  always_comb begin
    id_ex_d = '0;
    if (bus.flush || stall_s) begin
      id_ex_d = '0;
    end else begin
      id_ex_d.npc      = bus.if_id_npc;
      id_ex_d.rs1_data = rs1_val_s;
      id_ex_d.rs2_data = rs2_val_s;
      id_ex_d.imm      = imm_s;
      id_ex_d.rs1      = rs1_idx_s;
      id_ex_d.rs2      = rs2_idx_s;
      id_ex_d.rd       = instr_s[11:7];
      id_ex_d.funct    = {instr_s[30], instr_s[14:12]};
      id_ex_d.ctrl     = ctrl_s;
    end
  end

  // Register file write from WB; x0 is never written.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (bus.wb_reg_write && (bus.wb_rd != 5'd0)) begin
      regs_q[bus.wb_rd] <= bus.wb_data;
    end
  end

  // ID/EX pipeline register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign bus.stall            = stall_s;
  assign bus.id_ex_npc        = id_ex_q.npc;
  assign bus.id_ex_rs1_data   = id_ex_q.rs1_data;
  assign bus.id_ex_rs2_data   = id_ex_q.rs2_data;
  assign bus.id_ex_imm        = id_ex_q.imm;
  assign bus.id_ex_rs1        = id_ex_q.rs1;
  assign bus.id_ex_rs2        = id_ex_q.rs2;
  assign bus.id_ex_rd         = id_ex_q.rd;
  assign bus.id_ex_funct      = id_ex_q.funct;
  assign bus.id_ex_reg_write  = id_ex_q.ctrl.reg_write;
  assign bus.id_ex_mem_read   = id_ex_q.ctrl.mem_read;
  assign bus.id_ex_mem_write  = id_ex_q.ctrl.mem_write;
  assign bus.id_ex_mem_to_reg = id_ex_q.ctrl.mem_to_reg;
  assign bus.id_ex_branch     = id_ex_q.ctrl.branch;
  assign bus.id_ex_alu_src    = id_ex_q.ctrl.alu_src;
  assign bus.id_ex_alu_op     = id_ex_q.ctrl.alu_op;

endmodule

// File: tb/tb_instruction_decode.sv
// Directed bench for instruction_decode with a per-cycle reference model of the ID stage.
module tb_instruction_decode;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  instruction_decode_if bus ();

  instruction_decode dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [31:0] npc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [3:0]  funct;
    logic [7:0]  ctl;  // {reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op}
  } mdl_t;

  mdl_t        exp_q;
  logic [31:0] mrf [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
    if (bus.wb_reg_write && bus.wb_rd == idx) return bus.wb_data;
`endif
    return mrf[idx];
  endfunction

  function automatic logic [7:0] ctl_of(input logic [6:0] op);
    case (op)
      7'h33:   return 8'b1000_0010;
      7'h13:   return 8'b1000_0110;
      7'h03:   return 8'b1101_0100;
      7'h23:   return 8'b0010_0100;
      7'h63:   return 8'b0000_1001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
  endfunction

  function automatic logic [31:0] imm_of(input logic [31:0] ins);
    int v;
    case (ins[6:0])
      7'h13, 7'h03: v = $signed(ins[31:20]);
      7'h23:        v = $signed({ins[31:25], ins[11:7]});
      7'h63:        v = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0});
      default:      v = 0;
    endcase
    return v;
  endfunction

  function automatic logic model_stall();
    logic [31:0] ins;
    ins = bus.if_id_instruction;
    if (bus.flush) return 1'b0;
    if (!exp_q.ctl[6] || exp_q.rd == 5'd0) return 1'b0;
    return (exp_q.rd == ins[19:15]) || (uses_rs2(ins[6:0]) && exp_q.rd == ins[24:20]);
  endfunction

  function automatic mdl_t model_decode();
    mdl_t        m;
    logic [31:0] ins;
    ins     = bus.if_id_instruction;
    m.npc   = bus.if_id_npc;
    m.rs1   = ins[19:15];
    m.rs2   = ins[24:20];
    m.rd    = ins[11:7];
    m.rs1d  = rf_read(m.rs1);
    m.rs2d  = rf_read(m.rs2);
    m.imm   = imm_of(ins);
    m.funct = {ins[30], ins[14:12]};
    m.ctl   = ctl_of(ins[6:0]);
    return m;
  endfunction

  // Reference model state: register file contents and the expected ID/EX register.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      exp_q <= '0;
      for (int i = 0; i < 32; i++) mrf[i] <= 32'd0;
    end else begin
      if (bus.flush || model_stall()) exp_q <= '0;
      else exp_q <= model_decode();
      if (bus.wb_reg_write && bus.wb_rd != 5'd0) mrf[bus.wb_rd] <= bus.wb_data;
    end
  end

  // Compare every DUT output against the model each cycle.
  always @(negedge clock) begin
    chk("npc", bus.id_ex_npc, exp_q.npc);
    chk("rs1_data", bus.id_ex_rs1_data, exp_q.rs1d);
    chk("rs2_data", bus.id_ex_rs2_data, exp_q.rs2d);
    chk("imm", bus.id_ex_imm, exp_q.imm);
    chk("rs1", {27'd0, bus.id_ex_rs1}, {27'd0, exp_q.rs1});
    chk("rs2", {27'd0, bus.id_ex_rs2}, {27'd0, exp_q.rs2});
    chk("rd", {27'd0, bus.id_ex_rd}, {27'd0, exp_q.rd});
    chk("funct", {28'd0, bus.id_ex_funct}, {28'd0, exp_q.funct});
    chk("ctl", {24'd0, bus.id_ex_reg_write, bus.id_ex_mem_read, bus.id_ex_mem_write,
                bus.id_ex_mem_to_reg, bus.id_ex_branch, bus.id_ex_alu_src, bus.id_ex_alu_op},
        {24'd0, exp_q.ctl});
    chk("stall", {31'd0, bus.stall}, {31'd0, (reset ? model_stall() : 1'b0)});
  end

  logic [31:0] pc_r;

  task automatic drive(input logic [31:0] ins, input logic fl, input logic wbw,
                       input logic [4:0] wrd, input logic [31:0] wdat);
    pc_r                  = pc_r + 32'd4;
    bus.if_id_instruction = ins;
    bus.if_id_npc         = pc_r;
    bus.flush             = fl;
    bus.wb_reg_write      = wbw;
    bus.wb_rd             = wrd;
    bus.wb_data           = wdat;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  localparam logic [31:0] NOP       = 32'h0000_0013;
  localparam logic [31:0] ADD_433   = 32'h0031_8233;
  localparam logic [31:0] ADDI_87   = 32'hFFF3_8413;
  localparam logic [31:0] LW_21     = 32'h0000_A103;
  localparam logic [31:0] ADD_526   = 32'h0061_02B3;
  localparam logic [31:0] SW_9_10   = 32'hFE95_2E23;
  localparam logic [31:0] ADD_400   = 32'h0000_0233;
  localparam logic [31:0] SUB_123   = 32'h4031_00B3;
  localparam logic [31:0] BEQ_M8    = 32'hFE20_8CE3;
  localparam logic [31:0] LUI_5     = 32'h1234_52B7;
  localparam logic [31:0] ADD_150   = 32'h0002_80B3;

  initial begin
    checks   = 0;
    failures = 0;
    pc_r     = 32'h0000_1000;
    reset    = 1'b0;
    bus.if_id_instruction = 32'd0;
    bus.if_id_npc         = 32'd0;
    bus.flush             = 1'b0;
    bus.wb_reg_write      = 1'b0;
    bus.wb_rd             = 5'd0;
    bus.wb_data           = 32'd0;
    #1;
    chk("reset_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
    chk("reset_npc", bus.id_ex_npc, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    drive(NOP, 1'b0, 1'b1, 5'd5, 32'h0000_0055); tick();
    drive(NOP, 1'b0, 1'b1, 5'd3, 32'h0000_00AA); tick();
    drive(ADD_433, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("add_rs1_data", bus.id_ex_rs1_data, 32'h0000_00AA);
    chk("add_rs2_data", bus.id_ex_rs2_data, 32'h0000_00AA);
    chk("add_alu_op", {30'd0, bus.id_ex_alu_op}, 32'd2);
    chk("add_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd1);

    drive(ADDI_87, 1'b0, 1'b1, 5'd7, 32'h0000_1234); tick();
`ifdef REGFILE_BYPASS_EN
    chk("addi_bypass_rs1", bus.id_ex_rs1_data, 32'h0000_1234);
`else
    chk("addi_nobypass_rs1", bus.id_ex_rs1_data, 32'd0);
`endif
    chk("addi_imm", bus.id_ex_imm, 32'hFFFF_FFFF);
    chk("addi_rd", {27'd0, bus.id_ex_rd}, 32'd8);
    drive(ADDI_87, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("addi_after_wb_rs1", bus.id_ex_rs1_data, 32'h0000_1234);

    drive(LW_21, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("lw_mem_read", {31'd0, bus.id_ex_mem_read}, 32'd1);
    drive(ADD_526, 1'b0, 1'b0, 5'd0, 32'd0); #1;
    chk("loaduse_stall", {31'd0, bus.stall}, 32'd1);
    tick();
    chk("bubble_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
    chk("bubble_rd", {27'd0, bus.id_ex_rd}, 32'd0);
    chk("stall_released", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("add_issue_rs1", {27'd0, bus.id_ex_rs1}, 32'd2);
    chk("add_issue_rd", {27'd0, bus.id_ex_rd}, 32'd5);

    drive(LW_21, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    drive(ADD_526, 1'b1, 1'b0, 5'd0, 32'd0); #1;
    chk("flush_kills_stall", {31'd0, bus.stall}, 32'd0);
    tick();
    chk("flush_bubble_rs1", {27'd0, bus.id_ex_rs1}, 32'd0);
    chk("flush_bubble_rw", {31'd0, bus.id_ex_reg_write}, 32'd0);

    drive(SW_9_10, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("sw_imm", bus.id_ex_imm, 32'hFFFF_FFFC);
    chk("sw_mem_write", {31'd0, bus.id_ex_mem_write}, 32'd1);
    chk("sw_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);

    drive(ADD_400, 1'b0, 1'b1, 5'd0, 32'h0000_FFFF); tick();
    chk("x0_same_cycle", bus.id_ex_rs1_data, 32'd0);
    drive(ADD_400, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("x0_after_write", bus.id_ex_rs1_data, 32'd0);

    drive(SUB_123, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("sub_funct", {28'd0, bus.id_ex_funct}, 32'd8);
    drive(BEQ_M8, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("beq_imm", bus.id_ex_imm, 32'hFFFF_FFF8);
    chk("beq_branch", {31'd0, bus.id_ex_branch}, 32'd1);
    drive(LUI_5, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("lui_rd", {27'd0, bus.id_ex_rd}, 32'd5);
    chk("lui_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);

    drive(LW_21, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    drive(ADD_526, 1'b0, 1'b0, 5'd0, 32'd0); #1;
    chk("pre_reset_stall", {31'd0, bus.stall}, 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("async_reset_reg_write", {31'd0, bus.id_ex_reg_write}, 32'd0);
    chk("async_reset_mem_read", {31'd0, bus.id_ex_mem_read}, 32'd0);
    chk("async_reset_npc", bus.id_ex_npc, 32'd0);
    chk("async_reset_stall", {31'd0, bus.stall}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    drive(ADD_150, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    chk("x5_cleared", bus.id_ex_rs1_data, 32'd0);
    chk("x5_index", {27'd0, bus.id_ex_rs1}, 32'd5);
    drive(NOP, 1'b0, 1'b0, 5'd0, 32'd0); tick();
    tick();

    @(negedge clock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_decode.md
Name: instruction_decode

Overview:
ID stage of the 5-stage RV32I pipeline, directly downstream of instruction fetch.
- Consumes the IF/ID instruction and next-PC.
- Reads the 32x32 register file, which is written back by WB.
- Generates immediates and control, detects load-use hazards (stall to IF), and registers everything into the ID/EX pipeline register.

Parameters:
XLEN, 32, datapath width
NREG, 32, architectural register count (x0 hardwired zero)

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
if_id_instruction  input  32  instruction from IF/ID
if_id_npc  input  32  PC+4 from IF/ID
flush  input  1  branch taken in EX/MEM; squash the instruction in ID
wb_reg_write  input  1  WB write enable
wb_rd  input  5  WB destination
wb_data  input  32  WB write data
stall  output  1  hold PC and IF/ID this cycle
id_ex_npc  output  32  registered npc
id_ex_rs1_data  output  32  registered rs1 value
id_ex_rs2_data  output  32  registered rs2 value
id_ex_imm  output  32  registered sign-extended immediate
id_ex_rs1  output  5  registered rs1 index (for forwarding)
id_ex_rs2  output  5  registered rs2 index
id_ex_rd  output  5  registered rd index
id_ex_funct  output  4  {funct7[5], funct3}
id_ex_reg_write  output  1  control
id_ex_mem_read  output  1  control
id_ex_mem_write  output  1  control
id_ex_mem_to_reg  output  1  control
id_ex_branch  output  1  control
id_ex_alu_src  output  1  0 = rs2, 1 = imm
id_ex_alu_op  output  2  00 add, 01 sub/compare, 10 funct-decoded

Behaviour:
- Reset (reset = 0, asynchronous): every id_ex_* output is 0, and all register-file entries are 0. stall is combinational and therefore 0 once the ID/EX register is cleared.
- Register file write: on the clock rising edge when wb_reg_write = 1 and wb_rd != 0. Writes to x0 are ignored; x0 always reads 0.
- Register file read: combinational on rs1 = instr[19:15] and rs2 = instr[24:20]. Same-cycle bypass is controlled by the optional feature below.
- Decode by opcode instr[6:0], giving (reg_write, mem_read, mem_write, mem_to_reg, branch, alu_src, alu_op):
  - 0110011 R-type: 1,0,0,0,0,0,10
  - 0010011 I-ALU: 1,0,0,0,0,1,10
  - 0000011 load: 1,1,0,1,0,1,00
  - 0100011 store: 0,0,1,0,0,1,00
  - 1100011 branch: 0,0,0,0,1,0,01
  - any other opcode: all controls 0 (a bubble); the datapath fields are still registered.
- Immediates, all sign-extended from instr[31]:
  - I-type: instr[31:20]
  - S-type: {instr[31:25], instr[11:7]}
  - B-type: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - R-type: 0
- rs2 is "used" only for R-type, store and branch.
- Load-use hazard, combinational: stall = id_ex_mem_read & (id_ex_rd != 0) & ((id_ex_rd == rs1) | (rs2 used & id_ex_rd == rs2)) & ~flush.
- ID/EX update each rising edge, in priority order:
  1. flush = 1: load a bubble (all controls 0, all data fields 0).
  2. stall = 1: load a bubble, so the decoded instruction is re-presented next cycle because IF holds.
  3. Otherwise: load the decoded values.
- Latency: one cycle from IF/ID to ID/EX. A stall lasts exactly one cycle per load-use pair, because the bubble clears id_ex_mem_read.
- Simultaneous flush and stall: flush wins and stall is forced to 0, so IF is not held.
- Reset asserted mid-operation: immediate clear regardless of the clock; no partial writeback survives.

Optional Feature:
REGFILE_BYPASS_EN
- Defined: a read whose index equals wb_rd while wb_reg_write = 1 and wb_rd != 0 returns wb_data in the same cycle (write-before-read).
- Undefined: reads return the stored, pre-write value; software or forwarding must cover the one-cycle WB-to-ID gap.

Test Plan:
- Reset low mid-run with id_ex_reg_write = 1 -> all id_ex_* = 0 and stall = 0 immediately, without a clock edge; after release, x5 reads 0.
- WB writes x3 = 0x0000_00AA, then the next cycle decodes add x4,x3,x3 (0x00318233) -> id_ex_rs1_data = id_ex_rs2_data = 0xAA, alu_op = 10, reg_write = 1.
- Same-cycle WB write x7 = 0x1234 while decoding addi x8,x7,-1 (0xFFF38413) -> with REGFILE_BYPASS_EN: rs1_data = 0x1234; without it: 0; in both cases imm = 0xFFFF_FFFF.
- lw x2,0(x1) followed by add x5,x2,x6 -> stall = 1 for exactly one cycle, ID/EX gets a bubble, then the add issues with rs1 = 2.
- flush = 1 in the same cycle as a load-use stall -> stall = 0 and ID/EX is a bubble.
- sw x9,-4(x10) (0xFE952E23) -> imm = 0xFFFF_FFFC, mem_write = 1, reg_write = 0. Write-back to x0 with data 0xFFFF -> x0 still reads 0.
